// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared widths, FSM state type and select decode for the 4-way arbiter
package arb_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic logic [N_REQ-1:0] onehot2(input logic [SEL_W-1:0] sel);
    return N_REQ'(1) << sel;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - round-robin winner select: rotate by ptr, fixed priority, rotate back
module rr_pick4
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] win,
  output logic             any
);

  logic [N_REQ-1:0] rot;
  logic [SEL_W-1:0] off;

  always_comb begin
    rot = '0;
    off = '0;
    // rot[0] is the requester at ptr, so the lowest set bit is the winner
    for (int k = 0; k < N_REQ; k++) begin
      rot[k] = req[SEL_W'(k) + ptr];
    end
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) off = SEL_W'(k);
    end
    win = off + ptr;
  end

  assign any = |req;

endmodule

// File: rtl/rr_mux_arbiter4.sv
// rtl/rr_mux_arbiter4.sv - round-robin arbiter driving a 4:1 mux select, with done/timeout release
module rr_mux_arbiter4
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             timeout
);

  localparam int CNT_W = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);

  state_t           state, state_nxt;
  logic [SEL_W-1:0] ptr, ptr_nxt;
  logic [CNT_W-1:0] hold_cnt, cnt_nxt;
  logic [N_REQ-1:0] gnt_nxt;
  logic [SEL_W-1:0] sel_nxt;
  logic             timeout_nxt;
  logic [SEL_W-1:0] win;
  logic             any;
  logic             at_limit;
  logic             grant;

  rr_pick4 u_pick (
    .req (req),
    .ptr (ptr),
    .win (win),
    .any (any)
  );

  assign at_limit = (HOLD_MAX != 0) && (hold_cnt == CNT_LIM);

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    cnt_nxt     = hold_cnt;
    gnt_nxt     = gnt;
    sel_nxt     = sel;
    timeout_nxt = 1'b0;
    grant       = 1'b0;
    case (state)
      IDLE: begin
        if (any) grant = 1'b1;
      end
      BUSY: begin
        if (hold_cnt != CNT_SAT) cnt_nxt = hold_cnt + 1'b1;
        if (done || at_limit) begin
          // a done that lands on the limit edge is an ordinary release
          timeout_nxt = at_limit && !done;
          if (any) begin
            grant = 1'b1;
          end else begin
            gnt_nxt   = '0;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (grant) begin
      gnt_nxt   = onehot2(win);
      sel_nxt   = win;
      ptr_nxt   = win + 1'b1;
      cnt_nxt   = '0;
      state_nxt = BUSY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
      sel      <= '0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= cnt_nxt;
      gnt      <= gnt_nxt;
      sel      <= sel_nxt;
      timeout  <= timeout_nxt;
    end
  end

  assign busy = (state == BUSY);

endmodule

// File: tb/tb_rr_mux_arbiter4.sv
// tb/tb_rr_mux_arbiter4.sv - directed bench for rr_mux_arbiter4 with HOLD_MAX=8
module tb_rr_mux_arbiter4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  rr_mux_arbiter4 #(.HOLD_MAX(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .sel     (sel),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] eg, input logic [1:0] es,
                     input logic eb, input logic et);
    checks++;
    assert ({gnt, sel, busy, timeout} === {eg, es, eb, et})
    else begin
      errors++;
      $error("FAIL %s: gnt=%b sel=%0d busy=%b timeout=%b expected gnt=%b sel=%0d busy=%b timeout=%b",
             tag, gnt, sel, busy, timeout, eg, es, eb, et);
    end
  endtask

  // Per-cycle invariants, sampled on the falling edge
  logic       mon_en = 1'b0;
  logic       p_busy = 1'b0, p_done = 1'b0, p_rst = 1'b1;
  logic [3:0] p_gnt = '0;
  logic [1:0] p_sel = '0;
  int         held = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      assert ((gnt & (gnt - 4'd1)) == 4'd0 && busy === (|gnt))
      else begin
        errors++;
        $error("FAIL inv_onehot: gnt=%b busy=%b expected one-hot/zero gnt and busy==|gnt", gnt, busy);
      end
      if (busy) begin
        checks++;
        assert (sel === {gnt[3] | gnt[2], gnt[3] | gnt[1]})
        else begin
          errors++;
          $error("FAIL inv_sel_idx: sel=%0d gnt=%b expected sel equal to index of gnt", sel, gnt);
        end
      end
      if (p_busy && !p_done && !p_rst && held < 7) begin
        checks++;
        assert (busy === 1'b1 && sel === p_sel && gnt === p_gnt)
        else begin
          errors++;
          $error("FAIL inv_stable: gnt=%b sel=%0d busy=%b expected gnt=%b sel=%0d busy=1",
                 gnt, sel, busy, p_gnt, p_sel);
        end
        held = busy ? held + 1 : 0;
      end else begin
        held = 0;
      end
      p_busy = busy;
      p_done = done;
      p_rst  = rst;
      p_gnt  = gnt;
      p_sel  = sel;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst  = 1'b1;
    req  = 4'b1111;
    done = 1'b0;

    // reset with all requests pending
    step();
    mon_en = 1'b1;
    chk("reset_c1", 4'b0000, 2'd0, 1'b0, 1'b0);
    step();
    chk("reset_c2", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    chk("first_grant", 4'b0001, 2'd0, 1'b1, 1'b0);

    // fairness: done every busy cycle
    done = 1'b1;
    step(); chk("rr_1", 4'b0010, 2'd1, 1'b1, 1'b0);
    step(); chk("rr_2", 4'b0100, 2'd2, 1'b1, 1'b0);
    step(); chk("rr_3", 4'b1000, 2'd3, 1'b1, 1'b0);
    step(); chk("rr_0", 4'b0001, 2'd0, 1'b1, 1'b0);
    req = 4'b0000;
    step(); chk("rr_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // pointer wrap: ptr=1 here, then ptr=3 after granting 2
    done = 1'b0;
    req  = 4'b0100;
    step(); chk("ptr_g1", 4'b0100, 2'd2, 1'b1, 1'b0);
    step(); chk("ptr_g2", 4'b0100, 2'd2, 1'b1, 1'b0);
    step(); chk("ptr_g3", 4'b0100, 2'd2, 1'b1, 1'b0);
    done = 1'b1;
    req  = 4'b0011;
    step(); chk("ptr_wrap", 4'b0001, 2'd0, 1'b1, 1'b0);
    req = 4'b0000;
    step(); chk("ptr_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // timeout: 8-cycle grant, pulse, sole-requester re-grant
    done = 1'b0;
    req  = 4'b0010;
    for (int i = 0; i < 8; i++) begin
      step(); chk($sformatf("to_hold_%0d", i), 4'b0010, 2'd1, 1'b1, 1'b0);
    end
    step(); chk("to_pulse", 4'b0010, 2'd1, 1'b1, 1'b1);
    step(); chk("to_after", 4'b0010, 2'd1, 1'b1, 1'b0);
    for (int i = 2; i < 8; i++) begin
      step(); chk($sformatf("to2_hold_%0d", i), 4'b0010, 2'd1, 1'b1, 1'b0);
    end
    // done coincides with the limit edge
    done = 1'b1;
    req  = 4'b0000;
    step(); chk("to_done_at_limit", 4'b0000, 2'd1, 1'b0, 1'b0);

    // dropped/changed req ignored while busy; ptr=2 so requester 0 wins
    done = 1'b0;
    req  = 4'b0001;
    step(); chk("drop_grant", 4'b0001, 2'd0, 1'b1, 1'b0);
    req = 4'b0000;
    step(); chk("drop_held", 4'b0001, 2'd0, 1'b1, 1'b0);
    req = 4'b1000;
    step(); chk("drop_other", 4'b0001, 2'd0, 1'b1, 1'b0);
    done = 1'b1;
    req  = 4'b0000;
    step(); chk("drop_release", 4'b0000, 2'd0, 1'b0, 1'b0);
    step(); chk("done_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // ptr=1: requester 2 wins, then rst+done together
    done = 1'b0;
    req  = 4'b0100;
    step(); chk("pre_rst_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
    rst  = 1'b1;
    done = 1'b1;
    req  = 4'b1111;
    step(); chk("rst_with_done", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst  = 1'b0;
    done = 1'b0;
    step(); chk("post_rst_grant", 4'b0001, 2'd0, 1'b1, 1'b0);

    @(negedge clk);
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
